router_port_deserializer: RTL and testbench

- Consumes one router output port's serial stream (dout/valido_n/frameo_n), assembles bytes LSB-first and buffers them in a small FIFO.
- Presents bytes on a valid/ready interface with an end-of-packet flag.
- Sits directly downstream of the router, one instance per output port.
- Flags framing errors and overflow, and counts good packets.

---
 rtl/router_port_deserializer.sv | 136 +++++++++++++
 tb/tb_router_port_deserializer.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/router_port_deserializer.sv
// Serial-to-byte deserializer for one router output port: assembles LSB-first bytes,
// buffers them in a small FIFO and reports framing/overflow errors and good-packet count.
//
// state | meaning
// IDLE  | waiting for frameo_n to fall; stray valido_n pulses ignored
// RECV  | inside a frame; valid bits shifted in, gaps ignored
module router_port_deserializer #(
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             frameo_n,
  input  logic             valido_n,
  input  logic             dout,
  output logic [7:0]       byte_data,
  output logic             byte_last,
  output logic             byte_valid,
  input  logic             byte_ready,
  output logic             busy,
  output logic             frame_err,
  output logic             ovf_err,
  output logic [CNT_W-1:0] pkt_count
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  typedef enum logic {IDLE, RECV} rxState_e;

  rxState_e       state, stateNext;
  logic [2:0]     bitCnt;
  logic [7:0]     shiftReg;
  logic [7:0]     assembled;
  logic           pktOvf;
  logic           sampleBit, pushReq, pushLast, endGood, endBad;

  logic [PTR_W:0] wrPtr, rdPtr;
  logic [7:0]     dataMem [FIFO_DEPTH];
  logic           lastMem [FIFO_DEPTH];
  logic           fifoEmpty, fifoFull, popEn, pushEn, dropByte;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    sampleBit = 1'b0;
    pushReq   = 1'b0;
    pushLast  = 1'b0;
    endGood   = 1'b0;
    endBad    = 1'b0;
    case (state)
      IDLE: begin
        if (!frameo_n) begin
          stateNext = RECV;
          sampleBit = !valido_n;
        end
      end
      RECV: begin
        if (!valido_n) begin
          sampleBit = 1'b1;
          if (bitCnt == 3'd7) begin
            pushReq  = 1'b1;
            pushLast = frameo_n;
          end
          if (frameo_n) begin
            stateNext = IDLE;
            endGood   = (bitCnt == 3'd7);
            endBad    = (bitCnt != 3'd7);
          end
        end else if (frameo_n) begin
          // frame dropped without a closing bit
          stateNext = IDLE;
          endBad    = 1'b1;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  always_comb begin
    assembled         = shiftReg;
    assembled[bitCnt] = dout;
  end

  assign fifoEmpty = (wrPtr == rdPtr);
  assign fifoFull  = (wrPtr[PTR_W] != rdPtr[PTR_W]) &&
                     (wrPtr[PTR_W-1:0] == rdPtr[PTR_W-1:0]);
  assign popEn     = byte_valid && byte_ready;
  // a pop on the same edge frees the slot the push needs
  assign pushEn    = pushReq && (!fifoFull || popEn);
  assign dropByte  = pushReq && fifoFull && !popEn;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      shiftReg  <= '0;
      bitCnt    <= '0;
      pktOvf    <= 1'b0;
      wrPtr     <= '0;
      rdPtr     <= '0;
      frame_err <= 1'b0;
      ovf_err   <= 1'b0;
      pkt_count <= '0;
    end else begin
      if (sampleBit) shiftReg <= assembled;

      if (endGood || endBad) bitCnt <= '0;
      else if (sampleBit)    bitCnt <= bitCnt + 3'd1;

      if (state == IDLE)  pktOvf <= 1'b0;
      else if (dropByte)  pktOvf <= 1'b1;

      if (endBad)   frame_err <= 1'b1;
      if (dropByte) ovf_err   <= 1'b1;
      if (endGood && !pktOvf && !dropByte) pkt_count <= pkt_count + CNT_W'(1);

      if (pushEn) wrPtr <= wrPtr + (PTR_W+1)'(1);
      if (popEn)  rdPtr <= rdPtr + (PTR_W+1)'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (pushEn) begin
      dataMem[wrPtr[PTR_W-1:0]] <= assembled;
      lastMem[wrPtr[PTR_W-1:0]] <= pushLast;
    end
  end

  assign byte_valid = !fifoEmpty;
  assign byte_data  = byte_valid ? dataMem[rdPtr[PTR_W-1:0]] : 8'h00;
  assign byte_last  = byte_valid ? lastMem[rdPtr[PTR_W-1:0]] : 1'b0;
  assign busy       = (state == RECV);

endmodule

// File: tb/tb_router_port_deserializer.sv
// Bench for router_port_deserializer: directed packets plus random traffic, scored
// against a packet-level model (expected byte queue, sticky flags, packet counter).
module tb_router_port_deserializer;

  localparam int DEPTH = 4;
  localparam int CW    = 4;

  logic          clock = 1'b0;
  logic          reset_n;
  logic          frameo_n, valido_n, dout, byte_ready;
  logic [7:0]    byte_data;
  logic          byte_last, byte_valid, busy, frame_err, ovf_err;
  logic [CW-1:0] pkt_count;

  always #5 clock = ~clock;

  router_port_deserializer #(.FIFO_DEPTH(DEPTH), .CNT_W(CW)) dut (
    .clock(clock), .reset_n(reset_n), .frameo_n(frameo_n), .valido_n(valido_n),
    .dout(dout), .byte_data(byte_data), .byte_last(byte_last), .byte_valid(byte_valid),
    .byte_ready(byte_ready), .busy(busy), .frame_err(frame_err), .ovf_err(ovf_err),
    .pkt_count(pkt_count)
  );

  int         checks = 0;
  int         failures = 0;
  logic [8:0] expQ[$];
  logic [7:0] txBytes[$];
  bit         expFrameErr, expOvfErr, expBusy, pktDrop;
  int         expPktCount;
  int         rdyMode;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic modelReset();
    expQ.delete();
    expFrameErr = 0;
    expOvfErr   = 0;
    expBusy     = 0;
    expPktCount = 0;
  endtask

  task automatic checkResetValues(input string tag);
    checkVal({tag, "_valid"}, 32'(byte_valid), 32'd0);
    checkVal({tag, "_data"},  32'(byte_data),  32'd0);
    checkVal({tag, "_last"},  32'(byte_last),  32'd0);
    checkVal({tag, "_busy"},  32'(busy),       32'd0);
    checkVal({tag, "_ferr"},  32'(frame_err),  32'd0);
    checkVal({tag, "_oerr"},  32'(ovf_err),    32'd0);
    checkVal({tag, "_cnt"},   32'(pkt_count),  32'd0);
  endtask

  // One clock: check DUT against model, advance the model across the coming edge, drive inputs.
  task automatic tick(input logic fr, input logic vl, input logic d,
                      input bit push, input logic [8:0] word);
    logic rdy;
    @(negedge clock);
    checkVal("valid", 32'(byte_valid), 32'(expQ.size() != 0));
    if (expQ.size() != 0) checkVal("head", 32'({byte_last, byte_data}), 32'(expQ[0]));
    checkVal("busy", 32'(busy), 32'(expBusy));
    checkVal("frame_err", 32'(frame_err), 32'(expFrameErr));
    checkVal("ovf_err", 32'(ovf_err), 32'(expOvfErr));
    checkVal("pkt_count", 32'(pkt_count), 32'(expPktCount));
    case (rdyMode)
      0:       rdy = 1'b0;
      1:       rdy = 1'b1;
      2:       rdy = 1'($urandom_range(0, 1));
      default: rdy = push;
    endcase
    if (rdy && expQ.size() != 0) void'(expQ.pop_front());
    if (push) begin
      if (expQ.size() < DEPTH) expQ.push_back(word);
      else begin
        expOvfErr = 1;
        pktDrop   = 1;
      end
    end
    expBusy    = !fr;
    frameo_n   = fr;
    valido_n   = vl;
    dout       = d;
    byte_ready = rdy;
  endtask

  task automatic idle(input int n, input bit noise);
    for (int k = 0; k < n; k++)
      tick(1'b1, noise ? 1'($urandom_range(0, 1)) : 1'b1, 1'($urandom_range(0, 1)), 0, '0);
  endtask

  // Sends nBits of txBytes LSB-first; abortEnd drops the frame after the bits instead.
  task automatic sendPacket(input int nBits, input bit abortEnd, input int gapLo, input int gapHi);
    logic [7:0] cur;
    logic       lastBit;
    int         g;
    pktDrop = 0;
    for (int i = 0; i < nBits; i++) begin
      g = $urandom_range(gapHi, gapLo);
      for (int k = 0; k < g; k++) tick(1'b0, 1'b1, 1'($urandom_range(0, 1)), 0, '0);
      lastBit = !abortEnd && (i == nBits - 1);
      cur     = txBytes[i / 8];
      tick(lastBit, 1'b0, cur[i % 8], (i % 8) == 7, {lastBit, cur});
    end
    if (abortEnd) tick(1'b1, 1'b1, 1'b0, 0, '0);
    if (abortEnd || (nBits % 8) != 0) expFrameErr = 1;
    else if (!pktDrop) expPktCount = (expPktCount + 1) % (1 << CW);
  endtask

  initial begin
    int nb, nBits, r;
    bit ab;
    reset_n    = 1'b0;
    frameo_n   = 1'b1;
    valido_n   = 1'b1;
    dout       = 1'b0;
    byte_ready = 1'b0;
    rdyMode    = 1;
    modelReset();
    repeat (3) @(negedge clock);
    checkResetValues("por");
    reset_n = 1'b1;
    idle(2, 0);

    // single clean byte
    txBytes = '{8'hA5};
    sendPacket(8, 0, 0, 0);
    idle(3, 0);

    // three bytes with two-cycle gaps between every bit
    txBytes = '{8'h01, 8'h80, 8'hFF};
    sendPacket(24, 0, 2, 2);
    idle(3, 0);

    // 12-bit packet, then a clean one
    txBytes = '{8'hC3, 8'h0F};
    sendPacket(12, 0, 0, 1);
    idle(2, 0);
    txBytes = '{8'h3C};
    sendPacket(8, 0, 0, 0);
    idle(3, 0);

    // fill the FIFO, then complete a byte on the same edge as a pop
    rdyMode = 0;
    txBytes = '{8'h10, 8'h20, 8'h30, 8'h40};
    sendPacket(32, 0, 0, 1);
    rdyMode = 3;
    txBytes = '{8'h77};
    sendPacket(8, 0, 0, 1);
    rdyMode = 1;
    idle(8, 0);

    // overflow: six bytes with no consumer
    rdyMode = 0;
    txBytes = '{8'hD1, 8'hD2, 8'hD3, 8'hD4, 8'hD5, 8'hD6};
    sendPacket(48, 0, 0, 0);
    idle(2, 0);
    rdyMode = 1;
    idle(8, 0);

    // async reset mid-byte with two bytes buffered
    rdyMode = 0;
    txBytes = '{8'h11, 8'h22};
    sendPacket(16, 0, 0, 0);
    for (int k = 0; k < 3; k++) tick(1'b0, 1'b0, 1'b1, 0, '0);
    #2;
    reset_n  = 1'b0;
    frameo_n = 1'b1;
    valido_n = 1'b1;
    #1;
    checkResetValues("midrst");
    modelReset();
    @(negedge clock);
    reset_n = 1'b1;
    rdyMode = 1;
    txBytes = '{8'h5A};
    sendPacket(8, 0, 0, 0);
    idle(3, 0);

    // random traffic: mixed lengths, short packets, aborts, random ready
    rdyMode = 2;
    for (int p = 0; p < 40; p++) begin
      nb = $urandom_range(1, 5);
      txBytes.delete();
      for (int k = 0; k < nb; k++) txBytes.push_back(8'($urandom));
      nBits = nb * 8;
      r     = $urandom_range(0, 9);
      ab    = (r == 2);
      if (r < 2) nBits = nBits - $urandom_range(1, 6);
      sendPacket(nBits, ab, 0, 2);
      idle($urandom_range(0, 3), 1);
    end
    rdyMode = 1;
    idle(10, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
